// File: rtl/mat2x2_pkg.sv
// ---------------------------------------------------------------------------
// mat2x2_pkg
// Shared definitions for the 2x2 unsigned matrix multiplier family: the
// operand loader, the multiplier itself and the result serializer.
//   ELEM_W / IN_W / MAX_VAL / TIMEOUT : element widths, legal range, idle limit
//   state_e   : operand loader FSM states
//   err_e     : rejection cause reported on err_code
//   A11..B22  : position of each element within an input frame
// ---------------------------------------------------------------------------
package mat2x2_pkg;

  localparam int ELEM_W  = 2;
  localparam int IN_W    = 3;
  localparam int MAX_VAL = 2;
  localparam int TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    ISSUE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_RANGE   = 2'd1,
    ERR_LEN     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  // Frame order: all of A row-major, then all of B row-major
  localparam logic [2:0] A11 = 3'd0;
  localparam logic [2:0] A12 = 3'd1;
  localparam logic [2:0] A21 = 3'd2;
  localparam logic [2:0] A22 = 3'd3;
  localparam logic [2:0] B11 = 3'd4;
  localparam logic [2:0] B12 = 3'd5;
  localparam logic [2:0] B21 = 3'd6;
  localparam logic [2:0] B22 = 3'd7;

  // elem_cnt is only 3 bits wide, so a full frame would alias back to 0;
  // the count stops at the last element index instead
  function automatic logic [2:0] nextElemCnt(input logic [2:0] cnt);
    return (cnt == B22) ? cnt : cnt + 3'd1;
  endfunction

endpackage

// File: rtl/mat2x2_operand_loader_if.sv
// ---------------------------------------------------------------------------
// mat2x2_operand_loader_if
// Bundles the element stream, the operand bus towards the multiplier and the
// error status of the operand loader.
//   in_valid/in_ready/in_data/in_last : element stream handshake
//   a_bus/b_bus/op_valid/op_ready     : packed operands and their handshake
//   err_pulse/err_code/elem_cnt       : status
// Modport slave is the loader's view; master is the surrounding system
// (stream producer plus multiplier).
// ---------------------------------------------------------------------------
interface mat2x2_operand_loader_if;
  import mat2x2_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W-1:0]       in_data;
  logic                  in_last;
  logic [4*ELEM_W-1:0]   a_bus;
  logic [4*ELEM_W-1:0]   b_bus;
  logic                  op_valid;
  logic                  op_ready;
  logic                  err_pulse;
  logic [1:0]            err_code;
  logic [2:0]            elem_cnt;

  modport slave (
    input  in_valid, in_data, in_last, op_ready,
    output in_ready, a_bus, b_bus, op_valid, err_pulse, err_code, elem_cnt
  );

  modport master (
    output in_valid, in_data, in_last, op_ready,
    input  in_ready, a_bus, b_bus, op_valid, err_pulse, err_code, elem_cnt
  );

endinterface

// File: rtl/mat2x2_elem_checker.sv
// ---------------------------------------------------------------------------
// mat2x2_elem_checker
// Purely combinational classification of the beat currently on the stream.
//   in_data   : raw element value (IN_W bits)
//   in_last   : frame terminator flag of the beat
//   elem_cnt  : index this beat would occupy in the frame
//   range_err : value exceeds MAX_VAL
//   short_err : frame terminated before its last element
//   long_err  : last element arrived without the terminator
// ---------------------------------------------------------------------------
module mat2x2_elem_checker
  import mat2x2_pkg::*;
(
  input  logic [IN_W-1:0] in_data,
  input  logic            in_last,
  input  logic [2:0]      elem_cnt,
  output logic            range_err,
  output logic            short_err,
  output logic            long_err
);

  // Classify the beat; priority between these is resolved by the loader FSM
  always_comb begin
    range_err = (in_data > IN_W'(MAX_VAL));
    short_err = in_last && (elem_cnt != B22);
    long_err  = !in_last && (elem_cnt == B22);
  end

endmodule

// File: rtl/mat2x2_operand_loader.sv
// ---------------------------------------------------------------------------
// mat2x2_operand_loader
// Collects an 8-element frame (A then B, row-major), range-checks each value
// and presents the packed operands to the multiplier with op_valid held until
// op_ready. Bad frames are swallowed and reported via err_pulse/err_code.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : global enable; low freezes the loader
//   bus        : element stream, operand bus and status (slave modport)
// ---------------------------------------------------------------------------
module mat2x2_operand_loader
  import mat2x2_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  mat2x2_operand_loader_if.slave     bus
);

  state_e                     state_q, state_d;
  logic [2:0]                 elemCnt_q, elemCnt_d;
  logic [7:0]                 toCnt_q, toCnt_d;
  err_e                       errCode_q, errCode_d;
  err_e                       drainCode_q, drainCode_d;
  logic                       errPulse_q;
  logic [7:0][ELEM_W-1:0]     elems_q;
  logic [4*ELEM_W-1:0]        aBus_q;
  logic [4*ELEM_W-1:0]        bBus_q;

  logic                       inReady;
  logic                       accept;
  logic                       errFire;
  logic                       elemWe;
  logic                       issueLoad;
  logic                       rangeErr;
  logic                       shortErr;
  logic                       longErr;

  mat2x2_elem_checker u_checker (
    .in_data   (bus.in_data),
    .in_last   (bus.in_last),
    .elem_cnt  (elemCnt_q),
    .range_err (rangeErr),
    .short_err (shortErr),
    .long_err  (longErr)
  );

  // ISSUE is the only state that refuses beats; ena gates everything
  assign inReady = ena && (state_q != ISSUE);
  assign accept  = bus.in_valid && inReady;

  // Next-state logic: every transition needs ena, so ena=0 holds all state
  always_comb begin
    state_d     = state_q;
    elemCnt_d   = elemCnt_q;
    toCnt_d     = toCnt_q;
    errCode_d   = errCode_q;
    drainCode_d = drainCode_q;
    errFire     = 1'b0;
    elemWe      = 1'b0;
    issueLoad   = 1'b0;

    unique case (state_q)
      IDLE, FILL: begin
        if (accept) begin
          toCnt_d = 8'd0;
          if (rangeErr) begin
            if (bus.in_last) begin
              errFire   = 1'b1;
              errCode_d = ERR_RANGE;
              elemCnt_d = 3'd0;
              state_d   = IDLE;
            end else begin
              drainCode_d = ERR_RANGE;
              elemCnt_d   = nextElemCnt(elemCnt_q);
              state_d     = DRAIN;
            end
          end else if (shortErr) begin
            errFire   = 1'b1;
            errCode_d = ERR_LEN;
            elemCnt_d = 3'd0;
            state_d   = IDLE;
          end else if (longErr) begin
            drainCode_d = ERR_LEN;
            state_d     = DRAIN;
          end else if (elemCnt_q == B22) begin
            // Element 7 goes straight onto b_bus, not into the buffer
            issueLoad = 1'b1;
            state_d   = ISSUE;
          end else begin
            elemWe    = 1'b1;
            elemCnt_d = nextElemCnt(elemCnt_q);
            state_d   = FILL;
          end
        end else if ((state_q == FILL) && ena) begin
          // Fires on the idle cycle that would take the count to TIMEOUT
          if (toCnt_q == 8'(TIMEOUT - 1)) begin
            errFire   = 1'b1;
            errCode_d = ERR_TIMEOUT;
            elemCnt_d = 3'd0;
            toCnt_d   = 8'd0;
            state_d   = IDLE;
          end else begin
            toCnt_d = toCnt_q + 8'd1;
          end
        end
      end
      DRAIN: begin
        if (accept && bus.in_last) begin
          errFire   = 1'b1;
          errCode_d = drainCode_q;
          elemCnt_d = 3'd0;
          state_d   = IDLE;
        end
      end
      ISSUE: begin
        if (ena && bus.op_ready) begin
          elemCnt_d = 3'd0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, frame buffer and operand registers; operands load only on ISSUE entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      elemCnt_q   <= 3'd0;
      toCnt_q     <= 8'd0;
      errCode_q   <= ERR_NONE;
      drainCode_q <= ERR_NONE;
      errPulse_q  <= 1'b0;
      elems_q     <= '0;
      aBus_q      <= '0;
      bBus_q      <= '0;
    end else begin
      state_q     <= state_d;
      elemCnt_q   <= elemCnt_d;
      toCnt_q     <= toCnt_d;
      errCode_q   <= errCode_d;
      drainCode_q <= drainCode_d;
      errPulse_q  <= errFire;
      if (elemWe) begin
        elems_q[elemCnt_q] <= bus.in_data[ELEM_W-1:0];
      end
      if (issueLoad) begin
        aBus_q <= elems_q[A22:A11];
        bBus_q <= {bus.in_data[ELEM_W-1:0], elems_q[B21], elems_q[B12], elems_q[B11]};
      end
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.a_bus     = aBus_q;
  assign bus.b_bus     = bBus_q;
  assign bus.op_valid  = (state_q == ISSUE);
  assign bus.err_pulse = errPulse_q;
  assign bus.err_code  = errCode_q;
  assign bus.elem_cnt  = elemCnt_q;

endmodule

// File: tb/tb_mat2x2_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_mat2x2_operand_loader
// Directed self-checking bench for mat2x2_operand_loader.
// ---------------------------------------------------------------------------
module tb_mat2x2_operand_loader;
  import mat2x2_pkg::*;

  logic clk;
  logic rst_n;
  logic ena;
  int   vectorsApplied = 0;
  int   miscompares    = 0;
  int   pulseCount     = 0;
  int   pulseBase;
  int   waitCycles;
  bit   seen;
  logic [7:0][2:0] frame;

  mat2x2_operand_loader_if busIf ();

  mat2x2_operand_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (busIf)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every err_pulse cycle, sampled away from the active edge
  always @(negedge clk) begin
    if (busIf.err_pulse === 1'b1) pulseCount <= pulseCount + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] d, input logic l);
    busIf.in_valid = v;
    busIf.in_data  = d;
    busIf.in_last  = l;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorsApplied++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic sendBeat(input logic [2:0] d, input logic l);
    applyStimulus(1'b1, d, l);
    tick();
    applyStimulus(1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    ena   = 1'b0;
    busIf.op_ready = 1'b0;
    applyStimulus(1'b0, 3'd0, 1'b0);
    tick();
    tick();

    // Reset state
    checkOutput("rst_op_valid", busIf.op_valid, 0);
    checkOutput("rst_a_bus", busIf.a_bus, 0);
    checkOutput("rst_b_bus", busIf.b_bus, 0);
    checkOutput("rst_err_pulse", busIf.err_pulse, 0);
    checkOutput("rst_err_code", busIf.err_code, 0);
    checkOutput("rst_elem_cnt", busIf.elem_cnt, 0);
    checkOutput("rst_in_ready", busIf.in_ready, 0);

    rst_n = 1'b1;
    ena   = 1'b1;
    busIf.op_ready = 1'b1;
    tick();
    checkOutput("idle_in_ready", busIf.in_ready, 1);

    // Valid frame 1,2,0,1,2,2,1,0
    pulseBase = pulseCount;
    frame = {3'd0, 3'd1, 3'd2, 3'd2, 3'd1, 3'd0, 3'd2, 3'd1};
    for (int i = 0; i < 3; i++) sendBeat(frame[i], 1'b0);
    checkOutput("v1_elem_cnt3", busIf.elem_cnt, 3);
    for (int i = 3; i < 7; i++) sendBeat(frame[i], 1'b0);
    checkOutput("v1_no_early_valid", busIf.op_valid, 0);
    sendBeat(frame[7], 1'b1);
    checkOutput("v1_op_valid", busIf.op_valid, 1);
    checkOutput("v1_a_bus", busIf.a_bus, 32'h49);
    checkOutput("v1_b_bus", busIf.b_bus, 32'h1A);
    checkOutput("v1_in_ready_issue", busIf.in_ready, 0);
    tick();
    checkOutput("v1_op_valid_drop", busIf.op_valid, 0);
    checkOutput("v1_elem_cnt_clr", busIf.elem_cnt, 0);
    checkOutput("v1_no_pulse", pulseCount - pulseBase, 0);

    // Range error on element 3, drain to in_last
    pulseBase = pulseCount;
    frame = {3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd1, 3'd1, 3'd1};
    for (int i = 0; i < 7; i++) sendBeat(frame[i], 1'b0);
    checkOutput("rng_no_pulse_yet", pulseCount - pulseBase, 0);
    checkOutput("rng_in_ready_drain", busIf.in_ready, 1);
    sendBeat(frame[7], 1'b1);
    checkOutput("rng_err_pulse", busIf.err_pulse, 1);
    checkOutput("rng_err_code", busIf.err_code, 1);
    checkOutput("rng_op_valid", busIf.op_valid, 0);
    tick();
    checkOutput("rng_pulse_once", pulseCount - pulseBase, 1);
    checkOutput("rng_code_sticky", busIf.err_code, 1);
    checkOutput("rng_a_bus_kept", busIf.a_bus, 32'h49);

    // Short frame: in_last on element 4
    for (int i = 0; i < 4; i++) sendBeat(3'd1, 1'b0);
    sendBeat(3'd1, 1'b1);
    checkOutput("short_err_pulse", busIf.err_pulse, 1);
    checkOutput("short_err_code", busIf.err_code, 2);
    checkOutput("short_elem_cnt", busIf.elem_cnt, 0);
    checkOutput("short_idle_ready", busIf.in_ready, 1);

    // Valid frame right after: 2,1,0,2,1,0,2,1
    frame = {3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
    for (int i = 0; i < 8; i++) sendBeat(frame[i], (i == 7));
    checkOutput("v2_op_valid", busIf.op_valid, 1);
    checkOutput("v2_a_bus", busIf.a_bus, 32'h86);
    checkOutput("v2_b_bus", busIf.b_bus, 32'h61);
    tick();
    checkOutput("v2_op_valid_drop", busIf.op_valid, 0);

    // Long frame: no in_last on element 7, terminated by a 9th beat
    pulseBase = pulseCount;
    for (int i = 0; i < 8; i++) sendBeat(3'd1, 1'b0);
    checkOutput("long_no_valid", busIf.op_valid, 0);
    sendBeat(3'd1, 1'b1);
    checkOutput("long_err_pulse", busIf.err_pulse, 1);
    checkOutput("long_err_code", busIf.err_code, 2);
    checkOutput("long_pulse_once", pulseCount - pulseBase, 0);
    tick();
    checkOutput("long_pulse_count", pulseCount - pulseBase, 1);

    // Timeout: 3 beats then silence
    for (int i = 0; i < 3; i++) sendBeat(3'd2, 1'b0);
    waitCycles = 0;
    seen = 1'b0;
    while (!seen && waitCycles < 300) begin
      tick();
      waitCycles++;
      if (busIf.err_pulse === 1'b1) seen = 1'b1;
    end
    checkOutput("to_seen", seen, 1);
    checkOutput("to_cycles", waitCycles, 255);
    checkOutput("to_err_code", busIf.err_code, 3);
    checkOutput("to_elem_cnt", busIf.elem_cnt, 0);
    checkOutput("to_a_bus_kept", busIf.a_bus, 32'h86);

    // Backpressure: 0,1,2,0,1,2,0,1 with op_ready low and ena toggling
    busIf.op_ready = 1'b0;
    frame = {3'd1, 3'd0, 3'd2, 3'd1, 3'd0, 3'd2, 3'd1, 3'd0};
    for (int i = 0; i < 8; i++) sendBeat(frame[i], (i == 7));
    checkOutput("bp_op_valid", busIf.op_valid, 1);
    checkOutput("bp_a_bus", busIf.a_bus, 32'h24);
    checkOutput("bp_b_bus", busIf.b_bus, 32'h49);
    applyStimulus(1'b1, 3'd1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      ena = i[0];
      tick();
      checkOutput("bp_hold_valid", busIf.op_valid, 1);
      checkOutput("bp_hold_a", busIf.a_bus, 32'h24);
      checkOutput("bp_hold_b", busIf.b_bus, 32'h49);
      checkOutput("bp_in_ready", busIf.in_ready, 0);
    end
    applyStimulus(1'b0, 3'd0, 1'b0);
    ena = 1'b0;
    busIf.op_ready = 1'b1;
    tick();
    checkOutput("bp_ena_low_holds", busIf.op_valid, 1);
    ena = 1'b1;
    tick();
    checkOutput("bp_handshake", busIf.op_valid, 0);
    checkOutput("bp_elem_cnt", busIf.elem_cnt, 0);
    checkOutput("bp_next_ready", busIf.in_ready, 1);

    // Async reset in the middle of FILL
    for (int i = 0; i < 5; i++) sendBeat(3'd1, 1'b0);
    checkOutput("rst_mid_cnt5", busIf.elem_cnt, 5);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstm_elem_cnt", busIf.elem_cnt, 0);
    checkOutput("rstm_op_valid", busIf.op_valid, 0);
    checkOutput("rstm_a_bus", busIf.a_bus, 0);
    checkOutput("rstm_b_bus", busIf.b_bus, 0);
    checkOutput("rstm_err_code", busIf.err_code, 0);
    checkOutput("rstm_err_pulse", busIf.err_pulse, 0);
    #2;
    rst_n = 1'b1;
    tick();
    frame = {3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2};
    for (int i = 0; i < 8; i++) sendBeat(frame[i], (i == 7));
    checkOutput("post_rst_valid", busIf.op_valid, 1);
    checkOutput("post_rst_a_bus", busIf.a_bus, 32'hAA);
    checkOutput("post_rst_b_bus", busIf.b_bus, 32'h55);
    checkOutput("post_rst_err_code", busIf.err_code, 0);
    tick();
    checkOutput("post_rst_drop", busIf.op_valid, 0);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
